// File: rtl/lcd_bus_decoder.sv
// Receive-side decoder for an HD44780-style 4-bit LCD bus: reassembles nibbles into bytes,
// tracks the cursor and keeps a 2x16 character buffer. Define LCD_DEC_CLEAR_EN to build the clear fill.
module lcd_bus_decoder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic       lcd_4,
  input  logic       lcd_5,
  input  logic       lcd_6,
  input  logic       lcd_7,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       byte_rs,
  output logic       mode4,
  output logic [6:0] ddram_addr,
  output logic       busy,
  output logic       overrun
);

  // state  | meaning
  // S_INIT8| 8-bit init: every E-fall is a full byte {nibble, 0}
  // S_HI   | 4-bit mode, waiting for the high nibble
  // S_LO   | 4-bit mode, waiting for the low nibble
  typedef enum logic [1:0] {S_INIT8, S_HI, S_LO} state_t;

  state_t     state, state_next;
  logic [6:0] sync_q [SYNC_STAGES];
  logic [6:0] s_bus;
  logic       e_prev;
  logic       nib_strobe;
  logic [3:0] hi_nib;
  logic       hi_rs;
  logic       take_byte;
  logic [7:0] asm_byte;
  logic       asm_rs;
  logic       inc_mode, inc_next;
  logic [6:0] addr_next;
  logic       buf_we;
  logic [4:0] buf_idx;
  logic [4:0] fill_idx;
  logic [7:0] char_buf [32];
`ifdef LCD_DEC_CLEAR_EN
  logic       clear_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      e_prev <= 1'b0;
    end else begin
      sync_q[0] <= {lcd_rs, lcd_rw, lcd_e, lcd_7, lcd_6, lcd_5, lcd_4};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      e_prev <= s_bus[4];
    end
  end

  assign s_bus      = sync_q[SYNC_STAGES-1];
  // Reads (RW=1) are invisible to the phase tracking.
  assign nib_strobe = e_prev & ~s_bus[4] & ~s_bus[5];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_INIT8;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    take_byte  = 1'b0;
    asm_byte   = 8'h00;
    asm_rs     = 1'b0;
    case (state)
      S_INIT8: if (nib_strobe) begin
        take_byte = 1'b1;
        asm_byte  = {s_bus[3:0], 4'h0};
        asm_rs    = s_bus[6];
        if (!s_bus[6] && s_bus[3:0] == 4'h2) state_next = S_HI;
      end
      S_HI: if (nib_strobe) state_next = S_LO;
      S_LO: if (nib_strobe) begin
        take_byte  = 1'b1;
        asm_byte   = {hi_nib, s_bus[3:0]};
        asm_rs     = hi_rs;
        state_next = S_HI;
      end
      default: state_next = S_INIT8;
    endcase
  end

  assign mode4 = (state != S_INIT8);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_nib     <= 4'h0;
      hi_rs      <= 1'b0;
      byte_valid <= 1'b0;
      byte_out   <= 8'h00;
      byte_rs    <= 1'b0;
    end else begin
      byte_valid <= take_byte;
      if (state == S_HI && nib_strobe) begin
        hi_nib <= s_bus[3:0];
        hi_rs  <= s_bus[6];
      end
      if (take_byte) begin
        byte_out <= asm_byte;
        byte_rs  <= asm_rs;
      end
    end
  end

  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
    logic [6:0] r;
    if (up) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  // Bytes arriving during a fill are reported but never executed.
  always_comb begin
    addr_next = ddram_addr;
    inc_next  = inc_mode;
    buf_we    = 1'b0;
    buf_idx   = 5'd0;
`ifdef LCD_DEC_CLEAR_EN
    clear_req = 1'b0;
`endif
    if (byte_valid && !busy) begin
      if (!byte_rs) begin
        if (byte_out[7]) begin
          addr_next = byte_out[6:0];
        end else if (byte_out[7:1] == 7'b0000001) begin
          addr_next = 7'h00;
        end else if (byte_out == 8'h01) begin
          addr_next = 7'h00;
          inc_next  = 1'b1;
`ifdef LCD_DEC_CLEAR_EN
          clear_req = 1'b1;
`endif
        end else if (byte_out[7:2] == 6'b000001) begin
          inc_next = byte_out[1];
        end
      end else begin
        buf_we    = (ddram_addr[6:4] == 3'b000) || (ddram_addr[6:4] == 3'b100);
        buf_idx   = {ddram_addr[6], ddram_addr[3:0]};
        addr_next = step_addr(ddram_addr, inc_mode);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ddram_addr <= 7'h00;
      inc_mode   <= 1'b1;
    end else begin
      ddram_addr <= addr_next;
      inc_mode   <= inc_next;
    end
  end

`ifdef LCD_DEC_CLEAR_EN
  // Fill is armed by reset so the buffer is blank after every reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b1;
      fill_idx <= 5'd0;
      overrun  <= 1'b0;
    end else begin
      if (byte_valid && busy) overrun <= 1'b1;
      if (clear_req) begin
        busy     <= 1'b1;
        fill_idx <= 5'd0;
      end else if (busy) begin
        fill_idx <= fill_idx + 5'd1;
        if (fill_idx == 5'd31) busy <= 1'b0;
      end
    end
  end
`else
  assign busy     = 1'b0;
  assign fill_idx = 5'd0;
  assign overrun  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (busy)        char_buf[fill_idx] <= BLANK_CHAR;
    else if (buf_we) char_buf[buf_idx]  <= byte_out;
  end

  assign rd_char = char_buf[rd_addr];

endmodule

// File: doc/lcd_bus_decoder.md
# lcd_bus_decoder

Receive-side model of the HD44780-style 4-bit LCD bus driven by `modultop`. It samples `lcd_rs`/`lcd_rw`/`lcd_e`/`lcd_4..7` in the system clock domain and reassembles nibbles into command and data bytes. It interprets the core command subset and maintains a 2×16 character buffer that the bench or an on-chip checker can read back. It sits on the far side of the LCD pins, alongside `modultop` in simulation or in a loop-back check build.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth on all bus inputs (≥2).
- `BLANK_CHAR`, 8'h20: fill value written by clear display.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state registers.
- `lcd_rs`, `lcd_rw`, `lcd_e`  in  1 each  LCD control pins.
- `lcd_4`..`lcd_7`  in  1 each  LCD data nibble; `lcd_7` is MSB.
- `rd_addr`  in  5  buffer read index: 0–15 line 1, 16–31 line 2.
- `rd_char`  out  8  combinational buffer read at `rd_addr`.
- `byte_valid`  out  1  one-cycle pulse when a full byte is assembled.
- `byte_out`  out  8  last assembled byte.
- `byte_rs`  out  1  RS captured with that byte's high nibble.
- `mode4`  out  1  1 = 4-bit mode established.
- `ddram_addr`  out  7  current cursor address.
- `busy`  out  1  clear fill in progress.
- `overrun`  out  1  sticky: a byte arrived while `busy`.

## Operation
- Every bus input passes through `SYNC_STAGES` flops. A falling edge (E-fall) is detected when the synchronised E was high in the previous cycle and is low in the current one. The nibble and RS are taken from the synchronised bus in that same cycle.
- E-falls with synchronised `lcd_rw`=1 are ignored entirely and do not advance the nibble phase.
- States:
  - `INIT8`: the reset state. Each E-fall is a full byte {nibble, 4'h0}. A command with bits[7:4]=4'h2 (function set, DL=0) moves to `HI`. Other commands execute normally.
  - `HI`: store the high nibble and RS, then go to `LO`.
  - `LO`: byte = {high, nibble}, then go back to `HI`. RS sampled in `LO` is discarded.
- Command decode (`byte_rs`=0), first match wins:
  - 1xxxxxxx: `ddram_addr` ← bits[6:0].
  - 0000001x: `ddram_addr` ← 0 (return home).
  - 00000001: `ddram_addr` ← 0, increment mode, start clear.
  - 000001ds: d=1 selects increment, d=0 selects decrement; s is ignored.
  - All other commands are accepted and have no effect.
- Data (`byte_rs`=1):
  - Address 0x00–0x0F writes buffer[addr]; 0x40–0x4F writes buffer[16+addr-0x40]; any other address is not stored.
  - The address then steps in the current direction.
- Address wrap:
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
  - Addresses outside 0x00–0x27 and 0x40–0x67 step ±1 modulo 128.
- Clear runs as a 5-bit fill counter writing `BLANK_CHAR` to index 0..31, one per cycle, with `busy`=1 for exactly 32 cycles. A byte completing while `busy` still updates `byte_*` and pulses `byte_valid`. It is not executed and sets `overrun`. `overrun` clears only on reset.

## Timing
- Reset values: `byte_valid`=0, `byte_out`=0, `byte_rs`=0, `mode4`=0, `ddram_addr`=0, increment mode, state `INIT8`, `overrun`=0, synchroniser flops 0.
- With `LCD_DEC_CLEAR_EN`, `busy`=1 out of reset. Otherwise `busy`=0.
- If E-fall is detected in cycle D, `byte_valid`, `byte_out`, `byte_rs` and `mode4` (on the switch) are updated in cycle D+1. The command or data effect (`ddram_addr`, buffer write, clear start) is visible in cycle D+2.
- `busy` rises in D+2 and falls after index 31 is written.
- E-falls must be ≥3 clocks apart; closer spacing is unsupported.
- Reset mid-byte discards the held high nibble. Reset mid-clear aborts the fill and, with `LCD_DEC_CLEAR_EN`, restarts it from index 0 after reset releases.
- Buffer contents are not reset.

## Configuration
- `LCD_DEC_CLEAR_EN` defined:
  - Clear-display fill logic is built.
  - An automatic fill also starts on reset release, so `busy` is high for 32 cycles after reset.
- `LCD_DEC_CLEAR_EN` undefined:
  - 0x01 only sets `ddram_addr`=0 and increment mode.
  - The buffer is untouched, `busy` is tied 0, and `overrun` never sets.

## Test plan
- Init: E-falls with nibbles 3,3,3,2 (RS=0) → `mode4`=0 after the first three and `mode4`=1 after the fourth; four `byte_valid` pulses with `byte_out`=0x30,0x30,0x30,0x20.
- 4-bit write: command 0x80, then data 0x41 ('A') → `byte_out`=0x41, `byte_rs`=1; `rd_addr`=0 reads 0x41; `ddram_addr`=0x01.
- Line 2 and wrap: set addr 0xCF (0x4F), write 'Z' → `rd_addr`=31 reads 0x5A. Set addr 0x27 and write a byte → `ddram_addr`=0x40. Entry 0x04, set 0x00, write a byte → `ddram_addr`=0x67.
- Clear (CLEAR_EN): fill line 1 with 'X', send 0x01 → `busy` high for 32 cycles; all 32 reads return 0x20; `ddram_addr`=0.
- Overrun: send data during `busy` → buffer unchanged, `overrun`=1 and held until reset.
- RW/reset: an E pulse with RW=1 between the high and low nibbles causes no phase advance. Reset between nibbles, then a fresh 4-bit write → `mode4`=0 and `INIT8` behaviour resumes.
